// File: rtl/mm_host_bridge.sv
// -----------------------------------------------------------------------------
// mm_host_bridge
//
// Host-side counterpart of the Montgomery multiplier top level. It owns the
// second port of the shared bridge BRAM and sequences one multiplication:
//   1. Accept 3*s+1 operand words from the host (p_prime_0, then p, a, b, each
//      least significant word first) and write them into the BRAM.
//   2. Pulse mm_start_o for one cycle and leave the BRAM port idle until the
//      multiplier reports mm_done_i.
//   3. Read the s result words back and stream them to the host.
//
// Ports:
//   clock_i, reset_n_i       single clock, asynchronous active-low reset
//   in_valid_i/in_ready_o    operand word channel, in_data_i carries the word
//   out_valid_o/out_ready_i  result word channel, out_data_o carries the word
//   mm_start_o               one-cycle start pulse to the multiplier
//   mm_done_i                multiplier done pulse (honoured only in WAIT)
//   BRAM_*                   BRAM port B; 1-cycle read latency on BRAM_dout_i
//   busy_o                   high in every state except IDLE
//   done_o                   one-cycle pulse after the last result is accepted
//
// Every output is a flop; the FSM and all outputs live in one always_ff.
// -----------------------------------------------------------------------------
module mm_host_bridge #(
    parameter int unsigned WORD_WIDTH     = 17,
    parameter int unsigned s              = 8,
    parameter int unsigned P_PRIME_0_ADDR = 0,
    parameter int unsigned P_BASE         = 1,
    parameter int unsigned A_BASE         = s + 1,
    parameter int unsigned B_BASE         = 2 * s + 1,
    parameter int unsigned RES_BASE       = 0
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    // host operand channel
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WORD_WIDTH-1:0] in_data_i,
    // host result channel
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_data_o,
    // multiplier control
    output logic                  mm_start_o,
    input  logic                  mm_done_i,
    // BRAM port
    output logic [31:0]           BRAM_addr_o,
    output logic [WORD_WIDTH-1:0] BRAM_din_o,
    input  logic [WORD_WIDTH-1:0] BRAM_dout_i,
    output logic                  BRAM_en_o,
    output logic                  BRAM_we_o,
    // status
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned ADDR_W = $clog2(4 * s);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StRdIssue,
        StRdCapt,
        StRdHold,
        StFin
    } state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       cnt_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [WORD_WIDTH-1:0]   din_q;
    logic                    en_q;
    logic                    we_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [WORD_WIDTH-1:0]   out_data_q;
    logic                    mm_start_q;
    logic                    busy_q;
    logic                    done_q;

    logic [31:0]             cnt_ext;
    logic [ADDR_W-1:0]       load_addr;
    logic [ADDR_W-1:0]       load_last;
    logic [ADDR_W-1:0]       rd_last;
    logic                    in_fire;

    assign cnt_ext   = 32'(cnt_q);
    assign load_last = ADDR_W'(3 * s);
    assign rd_last   = ADDR_W'(s - 1);
    // Handshake qualified by the registered ready, which is what the host sees.
    assign in_fire   = in_valid_i && in_ready_q;

    // Operand word index -> BRAM address. The four regions are independent so
    // the bases may be relocated without touching the sequencing logic.
    always_comb begin
        load_addr = ADDR_W'(P_PRIME_0_ADDR);
        if (cnt_q == '0) begin
            load_addr = ADDR_W'(P_PRIME_0_ADDR);
        end else if (cnt_ext <= 32'(s)) begin
            load_addr = ADDR_W'(P_BASE + cnt_ext - 32'd1);
        end else if (cnt_ext <= 32'(2 * s)) begin
            load_addr = ADDR_W'(A_BASE + cnt_ext - 32'(s) - 32'd1);
        end else begin
            load_addr = ADDR_W'(B_BASE + cnt_ext - 32'(2 * s) - 32'd1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mm_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Pulses and the BRAM port default to inactive; states that need
            // them assert them for exactly the cycle that follows.
            mm_start_q <= 1'b0;
            done_q     <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;

            unique case (state_q)
                StIdle, StLoad: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        en_q   <= 1'b1;
                        we_q   <= 1'b1;
                        din_q  <= in_data_i;
                        addr_q <= load_addr;
                        busy_q <= 1'b1;
                        if (cnt_q == load_last) begin
                            // Last operand word: close the channel at once so
                            // no further word can be consumed.
                            in_ready_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= StStart;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= StLoad;
                        end
                    end
                end

                StStart: begin
                    // The final write is on the port this cycle; start follows it.
                    mm_start_q <= 1'b1;
                    state_q    <= StWait;
                end

                StWait: begin
                    // Port stays idle here so the multiplier owns the BRAM.
                    if (mm_done_i) begin
                        cnt_q   <= '0;
                        en_q    <= 1'b1;
                        addr_q  <= ADDR_W'(RES_BASE);
                        state_q <= StRdIssue;
                    end
                end

                StRdIssue: begin
                    state_q <= StRdCapt;
                end

                StRdCapt: begin
                    // Read data is valid one cycle after the enabled read.
                    out_data_q  <= BRAM_dout_i;
                    out_valid_q <= 1'b1;
                    state_q     <= StRdHold;
                end

                StRdHold: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (cnt_q < rd_last) begin
                            cnt_q   <= cnt_q + 1'b1;
                            en_q    <= 1'b1;
                            addr_q  <= ADDR_W'(RES_BASE + cnt_ext + 32'd1);
                            state_q <= StRdIssue;
                        end else begin
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end
                    end
                end

                StFin: begin
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign mm_start_o  = mm_start_q;
    assign BRAM_addr_o = 32'(addr_q);
    assign BRAM_din_o  = din_q;
    assign BRAM_en_o   = en_q;
    assign BRAM_we_o   = we_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mm_host_bridge.sv
`timescale 1ns/1ps
module tb_mm_host_bridge;
    localparam int unsigned WW   = 17;
    localparam int unsigned S    = 2;
    localparam int unsigned NW   = 3 * S + 1;
    localparam int unsigned AW   = $clog2(4 * S);
    localparam int unsigned MEMD = 4 * S;
    // Memory map of the default build.
    localparam int unsigned P0 = 0;
    localparam int unsigned PB = 1;
    localparam int unsigned AB = S + 1;
    localparam int unsigned BB = 2 * S + 1;
    localparam int unsigned RB = 0;

    logic          clock_i     = 1'b0;
    logic          reset_n_i   = 1'b0;
    logic          in_valid_i  = 1'b0;
    logic          in_ready_o;
    logic [WW-1:0] in_data_i   = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [WW-1:0] out_data_o;
    logic          mm_start_o;
    logic          mm_done_i   = 1'b0;
    logic [31:0]   BRAM_addr_o;
    logic [WW-1:0] BRAM_din_o;
    logic [WW-1:0] BRAM_dout_i = '0;
    logic          BRAM_en_o;
    logic          BRAM_we_o;
    logic          busy_o;
    logic          done_o;

    always #5 clock_i = ~clock_i;

    mm_host_bridge #(.WORD_WIDTH(WW), .s(S)) dut (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .mm_start_o (mm_start_o),
        .mm_done_i  (mm_done_i),
        .BRAM_addr_o(BRAM_addr_o),
        .BRAM_din_o (BRAM_din_o),
        .BRAM_dout_i(BRAM_dout_i),
        .BRAM_en_o  (BRAM_en_o),
        .BRAM_we_o  (BRAM_we_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // Shared BRAM: port B is the DUT, port A is the emulated multiplier.
    logic          mul_we   = 1'b0;
    logic [AW-1:0] mul_addr = '0;
    logic [WW-1:0] mul_din  = '0;
    logic [WW-1:0] mem [MEMD];

    always @(posedge clock_i) begin
        if (mul_we) mem[mul_addr] <= mul_din;
        if (BRAM_en_o) begin
            if (BRAM_we_o) mem[BRAM_addr_o[AW-1:0]] <= BRAM_din_o;
            else           BRAM_dout_i <= mem[BRAM_addr_o[AW-1:0]];
        end
    end

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1, "global timeout");
    end

    // Scoreboard / reference model state.
    typedef struct {
        logic [31:0]   addr;
        logic [WW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t           exp_wr_q[$];
    int            exp_start_q[$];
    logic [31:0]   exp_rd_q[$];
    logic [WW-1:0] exp_out_q[$];
    logic [WW-1:0] ref_mem [MEMD];

    int tests = 0;
    int fails = 0;

    bit            mon_on;
    bit            mm_owned;
    bit            prev_valid;
    bit            prev_ready;
    logic [WW-1:0] prev_data;
    bit            valid_pending;
    int            exp_valid_cyc;
    bit            done_pending;
    int            exp_done_cyc;

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
        end
    endfunction

    function automatic void flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s @cyc %0d: got unexpected event, expected none", name, cyc);
    endfunction

    // Word index k of the host stream -> address, straight from the memory map.
    function automatic logic [31:0] spec_addr(input int k);
        if (k == 0)                 return 32'(P0);
        else if (k <= int'(S))      return 32'(PB + k - 1);
        else if (k <= int'(2 * S))  return 32'(AB + k - int'(S) - 1);
        else                        return 32'(BB + k - int'(2 * S) - 1);
    endfunction

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clock_i);
            if (!reset_n_i || !mon_on) begin
                prev_valid = 0; prev_ready = 0; valid_pending = 0;
                done_pending = 0; mm_owned = 0;
                continue;
            end
            if (BRAM_en_o && BRAM_we_o) begin
                if (exp_wr_q.size() == 0) flag("unexpected_write");
                else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", BRAM_addr_o, e.addr);
                    chk("wr_data", 32'(BRAM_din_o), 32'(e.data));
                    chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (BRAM_en_o && !BRAM_we_o) begin
                if (exp_rd_q.size() == 0) flag("unexpected_read");
                else begin
                    chk("rd_addr", BRAM_addr_o, exp_rd_q.pop_front());
                    valid_pending = 1;
                    exp_valid_cyc = cyc + 2;
                end
                if (out_valid_o) flag("read_while_valid");
            end
            if (BRAM_en_o && mm_owned) flag("bram_during_mult");
            if (mm_done_i) mm_owned = 0;
            if (mm_start_o) begin
                if (exp_start_q.size() == 0) flag("unexpected_start");
                else chk("start_cycle", 32'(cyc), 32'(exp_start_q.pop_front()));
                mm_owned = 1;
            end
            if (out_valid_o && !prev_valid) begin
                if (!valid_pending) flag("unexpected_valid");
                else begin
                    chk("valid_cycle", 32'(cyc), 32'(exp_valid_cyc));
                    valid_pending = 0;
                end
            end
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(out_valid_o), 32'd1);
                chk("hold_data", 32'(out_data_o), 32'(prev_data));
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_out_q.size() == 0) flag("unexpected_output");
                else begin
                    chk("out_data", 32'(out_data_o), 32'(exp_out_q.pop_front()));
                    if (exp_out_q.size() == 0) begin
                        done_pending = 1;
                        exp_done_cyc = cyc + 1;
                    end
                end
            end
            if (done_o) begin
                if (!done_pending) flag("unexpected_done");
                else begin
                    chk("done_cycle", 32'(cyc), 32'(exp_done_cyc));
                    done_pending = 0;
                end
            end
            prev_valid = out_valid_o;
            prev_ready = out_ready_i;
            prev_data  = out_data_o;
        end
    endtask

    // vmode: 0 full rate, 1 toggling valid, 2 random valid.
    task automatic load_op(input logic [WW-1:0] words [NW], input int vmode, input bit spurious);
        int  k = 0;
        int  budget = 0;
        bit  tog = 1'b0;
        bit  pulsed = 1'b0;
        bit  chk_next = 1'b0;
        wr_t e;
        while (k < int'(NW)) begin
            @(posedge clock_i); #1;
            mm_done_i = 1'b0;
            case (vmode)
                0:       in_valid_i = 1'b1;
                1:       begin tog = ~tog; in_valid_i = tog; end
                default: in_valid_i = 1'($urandom_range(0, 1));
            endcase
            in_data_i = words[k];
            if (spurious && !pulsed && k == 3) begin
                mm_done_i = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge clock_i);
            if (chk_next) begin
                chk("spurious_done_ready", 32'(in_ready_o), 32'd1);
                chk("spurious_done_busy", 32'(busy_o), 32'd1);
                chk_next = 1'b0;
            end
            if (mm_done_i) chk_next = 1'b1;
            if (in_valid_i && in_ready_o) begin
                e.addr = spec_addr(k);
                e.data = words[k];
                e.cyc  = cyc + 1;
                exp_wr_q.push_back(e);
                ref_mem[e.addr[AW-1:0]] = words[k];
                if (k == int'(NW) - 1) exp_start_q.push_back(cyc + 2);
                k++;
            end
            budget++;
            if (budget > 200) begin
                flag("load_timeout");
                break;
            end
        end
        @(posedge clock_i); #1;
        in_valid_i = 1'b0;
        mm_done_i  = 1'b0;
        in_data_i  = '0;
    endtask

    task automatic wait_start_and_idle();
        int n = 0;
        int w;
        while (!mm_start_o && n < 20) begin
            @(negedge clock_i);
            n++;
        end
        if (!mm_start_o) flag("start_timeout");
        // Host keeps offering words during WAIT; none may be consumed.
        w = int'($urandom_range(2, 5));
        for (int i = 0; i < w; i++) begin
            @(posedge clock_i); #1;
            in_valid_i = 1'($urandom_range(0, 1));
            in_data_i  = WW'($urandom);
            @(negedge clock_i);
            chk("wait_in_ready", 32'(in_ready_o), 32'd0);
            chk("wait_busy", 32'(busy_o), 32'd1);
        end
        @(posedge clock_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic mult_and_readback(input logic [WW-1:0] res [S], input int rmode,
                                     input int stall);
        int n = 0;
        int left = stall;
        int dones = 0;
        for (int i = 0; i < int'(S); i++) begin
            @(posedge clock_i); #1;
            mul_we   = 1'b1;
            mul_addr = AW'(RB + i);
            mul_din  = res[i];
            ref_mem[AW'(RB + i)] = res[i];
        end
        @(posedge clock_i); #1;
        mul_we = 1'b0;
        for (int i = 0; i < int'(S); i++) begin
            exp_rd_q.push_back(32'(RB + i));
            exp_out_q.push_back(ref_mem[AW'(RB + i)]);
        end
        mm_done_i   = 1'b1;
        out_ready_i = (left > 0) ? 1'b0 : (rmode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
        @(posedge clock_i); #1;
        mm_done_i = 1'b0;
        while (dones == 0 && n < 200) begin
            @(negedge clock_i);
            if (done_o) dones++;
            if (out_valid_o && !out_ready_i && left > 0) begin
                chk("stall_data", 32'(out_data_o), 32'(res[0]));
                left--;
            end
            @(posedge clock_i); #1;
            out_ready_i = (left > 0) ? 1'b0 : (rmode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
            n++;
        end
        if (dones == 0) flag("done_timeout");
        @(negedge clock_i);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_ready", 32'(in_ready_o), 32'd1);
        chk("idle_done_low", 32'(done_o), 32'd0);
        chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        chk("out_queue_drained", 32'(exp_out_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data_o), 32'd0);
        chk({tag, "_mm_start"}, 32'(mm_start_o), 32'd0);
        chk({tag, "_bram_addr"}, BRAM_addr_o, 32'd0);
        chk({tag, "_bram_din"}, 32'(BRAM_din_o), 32'd0);
        chk({tag, "_bram_en"}, 32'(BRAM_en_o), 32'd0);
        chk({tag, "_bram_we"}, 32'(BRAM_we_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
    endtask

    logic [WW-1:0] fixed_words [NW];
    logic [WW-1:0] rnd_words [NW];
    logic [WW-1:0] fixed_res [S];
    logic [WW-1:0] rnd_res [S];

    initial begin
        mon_on = 1'b0;
        for (int i = 0; i < int'(NW); i++) fixed_words[i] = WW'(17 * (i + 1));
        fixed_res[0] = 17'h1ABCD;
        fixed_res[1] = 17'h00F0F;
        fork
            monitor();
        join_none

        // Power-on reset, then release between clock edges.
        #12;
        check_reset_outputs("por");
        @(posedge clock_i); @(posedge clock_i); #3;
        reset_n_i = 1'b1;
        mon_on    = 1'b1;
        #1;
        chk("release_ready_before_edge", 32'(in_ready_o), 32'd0);
        @(posedge clock_i); #1;
        chk("release_ready_after_edge", 32'(in_ready_o), 32'd1);

        // Full-rate load, readback with ready held high.
        load_op(fixed_words, 0, 1'b0);
        wait_start_and_idle();
        mult_and_readback(fixed_res, 0, 0);

        // Gapped load with a stray done, then 5 cycles of backpressure.
        load_op(fixed_words, 1, 1'b1);
        wait_start_and_idle();
        mult_and_readback(fixed_res, 0, 5);

        // Asynchronous reset while waiting for the multiplier.
        for (int i = 0; i < int'(NW); i++) rnd_words[i] = WW'($urandom);
        load_op(rnd_words, 0, 1'b0);
        wait_start_and_idle();
        @(posedge clock_i); #3;
        reset_n_i = 1'b0;
        #1;
        check_reset_outputs("mid");
        exp_wr_q.delete();
        exp_start_q.delete();
        exp_rd_q.delete();
        exp_out_q.delete();
        @(posedge clock_i); @(posedge clock_i); #3;
        reset_n_i = 1'b1;
        #1;
        chk("mid_release_ready", 32'(in_ready_o), 32'd0);
        load_op(fixed_words, 0, 1'b0);
        wait_start_and_idle();
        mult_and_readback(fixed_res, 0, 0);

        // Randomised operations.
        for (int op = 0; op < 6; op++) begin
            for (int i = 0; i < int'(NW); i++) rnd_words[i] = WW'($urandom);
            for (int i = 0; i < int'(S); i++) rnd_res[i] = WW'($urandom);
            load_op(rnd_words, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            wait_start_and_idle();
            mult_and_readback(rnd_res, 1, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mm_host_bridge.md
Name: mm_host_bridge

Overview:
- Host-side counterpart of the Montgomery multiplier top level. It drives the second port of the shared bridge BRAM.
- The host streams in operands over a valid/ready channel: p_prime_0, then p, a and b, each least significant word first. The bridge writes these words into the BRAM.
- It then pulses the multiplier start and waits for multiplier done.
- Finally it reads the s result words back out of the BRAM and streams them to the host over a valid/ready channel.

Parameters:
- WORD_WIDTH, 17, width of one operand word.
- s, 8, number of words per operand.
- P_PRIME_0_ADDR, 0, BRAM address of p_prime_0.
- P_BASE, 1, BRAM address of p word 0.
- A_BASE, s+1, BRAM address of a word 0.
- B_BASE, 2*s+1, BRAM address of b word 0.
- RES_BASE, 0, BRAM address of result word 0. This region overwrites the p_prime_0/p words once the multiplication has finished.
- ADDR_W (localparam), $clog2(4*s), width of the significant address bits.

Ports:
- clock_i  in  1  single clock
- reset_n_i  in  1  asynchronous, active-low reset
- in_valid_i  in  1  host operand word valid
- in_ready_o  out  1  bridge accepts operand word
- in_data_i  in  WORD_WIDTH  operand word
- out_valid_o  out  1  result word valid
- out_ready_i  in  1  host accepts result word
- out_data_o  out  WORD_WIDTH  result word
- mm_start_o  out  1  one-cycle start pulse to the multiplier
- mm_done_i  in  1  multiplier done pulse
- BRAM_addr_o  out  32  BRAM address; ADDR_W bits, zero-extended
- BRAM_din_o  out  WORD_WIDTH  BRAM write data
- BRAM_dout_i  in  WORD_WIDTH  BRAM read data, 1-cycle read latency
- BRAM_en_o  out  1  BRAM enable
- BRAM_we_o  out  1  BRAM write enable
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the last result word is accepted

Behaviour:
- Reset: reset_n_i low asynchronously clears everything.
  - All outputs go to 0: in_ready_o, out_valid_o, out_data_o, mm_start_o, BRAM_*, busy_o, done_o.
  - The FSM goes to IDLE and the word counter goes to 0.
  - This applies mid-operation too. BRAM contents are not touched.
  - After reset release, in_ready_o rises on the first clock edge.
- All outputs are registered.
- FSM states: IDLE, LOAD, START, WAIT, RD_ISSUE, RD_CAPT, RD_HOLD, FIN.
- IDLE/LOAD (operand load):
  - in_ready_o=1.
  - A handshake is in_valid_i & in_ready_o at cycle T. At T+1 the bridge drives BRAM_en_o=1, BRAM_we_o=1, BRAM_din_o=in_data_i and the address below.
  - One word is accepted per cycle at full rate.
  - Address mapping, by counter value c:
    - c=0: P_PRIME_0_ADDR
    - c=1..s: P_BASE+c-1
    - c=s+1..2s: A_BASE+c-s-1
    - c=2s+1..3s: B_BASE+c-2s-1
  - The first handshake moves IDLE to LOAD.
- START:
  - The handshake at c=3s (word 3s+1) at cycle T gives in_ready_o=0 from T+1, the last write at T+1, and mm_start_o=1 for exactly cycle T+2.
  - The FSM is in WAIT from T+2 on.
- WAIT:
  - in_ready_o=0 and the BRAM port is idle (en=0, we=0).
  - mm_done_i high moves the FSM to RD_ISSUE with the counter at 0.
  - mm_done_i is ignored in every other state.
- Result read:
  - RD_ISSUE at cycle R drives BRAM_en_o=1, BRAM_we_o=0, addr=RES_BASE+c.
  - BRAM_dout_i is valid at R+1 (RD_CAPT) and is registered into out_data_o.
  - out_valid_o=1 from R+2 (RD_HOLD) until out_ready_i is sampled high.
  - On acceptance, out_valid_o drops the next cycle and the counter increments. If c<s-1 the FSM returns to RD_ISSUE, otherwise it goes to FIN.
  - Minimum 3 cycles per word, even with out_ready_i held high.
  - out_data_o is stable while out_valid_o is high and out_ready_i is low.
- FIN: done_o=1 for one cycle, then IDLE.
- in_valid_i outside IDLE/LOAD is ignored; no word is consumed.
- out_ready_i while out_valid_o=0 is ignored.
- Bridge BRAM_en_o/BRAM_we_o are never asserted between mm_start_o and mm_done_i, so the multiplier has exclusive port use.

Test Plan:
- Setup for all scenarios: s=2, WORD_WIDTH=17, default bases, so p'0@0, p@1-2, a@3-4, b@5-6, res@0-1.
- Full load at full rate:
  - Stimulus: in_data 0x00011, 0x00022, 0x00033, 0x00044, 0x00055, 0x00066, 0x00077 back-to-back.
  - Response: BRAM writes at addr 0..6 with those values on consecutive cycles; mm_start_o high exactly 2 cycles after the 7th handshake, one cycle wide; in_ready_o=0 from then on.
- Gapped load:
  - Stimulus: in_valid toggling 1/0 each cycle.
  - Response: addresses still 0..6 in order, no duplicate or skipped writes, start timing relative to the last handshake unchanged.
- Result readback:
  - Stimulus: BRAM model holds 0x1ABCD@0 and 0x00F0F@1; pulse mm_done_i; out_ready_i held high.
  - Response: reads at addr 0 then 1; out_data 0x1ABCD then 0x00F0F, each valid 2 cycles after its RD_ISSUE; done_o pulses once; back to IDLE.
- Backpressure and ignored inputs:
  - Stimulus: out_ready_i low for 5 cycles on the first word; also pulse mm_done_i during LOAD.
  - Response: out_data stays 0x1ABCD with out_valid high for all 5 cycles; no second read issued; the spurious done is ignored and the FSM stays in LOAD.
- Reset mid-operation:
  - Stimulus: assert reset_n_i low asynchronously (between clock edges) during WAIT, then release and reload.
  - Response: all outputs go to 0 immediately without a clock edge; the FSM is in IDLE; the new load restarts at addr 0.
